// File: rtl/data_sram_rsp.sv
// Data-side SRAM-like responder: word memory plus an in-order response queue.
// Optional random accept/response holdoff is enabled by defining DATA_SRAM_RSP_RAND_DELAY_EN.
module data_sram_rsp #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4,
    parameter int LAT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL  = (PW+1)'(DEPTH);
    localparam logic [3:0]  LAT_C = 4'(LAT);

    logic              resetn_q;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW:0]       count;
    logic              stall_a;
    logic              stall_d;
    logic              acc;
    logic              rel;
    logic [ADDR_W-1:0] widx;

    logic [31:0] mem     [0:(1<<ADDR_W)-1];
    logic        q_wr    [DEPTH];
    logic [31:0] q_rdata [DEPTH];
    logic [3:0]  q_age   [DEPTH];

    // Transfer size and bits outside the word index carry no meaning here.
    logic unused;
    assign unused = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DATA_SRAM_RSP_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall_a = lfsr[0] & lfsr[1];
    assign stall_d = lfsr[2] & lfsr[3];
`else
    assign stall_a = 1'b0;
    assign stall_d = 1'b0;
`endif

    assign widx = data_sram_addr[ADDR_W+1:2];

    // Gating with resetn keeps both channels quiet during the reset cycle itself.
    assign data_sram_addr_ok = resetn & resetn_q & (count < FULL) & ~stall_a;
    assign acc = data_sram_req & data_sram_addr_ok;
    assign rel = resetn & (count != '0) & (q_age[rptr] >= LAT_C) & ~stall_d;

    assign data_sram_data_ok = rel;
    assign data_sram_rdata   = (rel && !q_wr[rptr]) ? q_rdata[rptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            resetn_q <= 1'b1;
            if (acc) begin
                wptr <= wptr + PW'(1);
            end
            if (rel) begin
                rptr <= rptr + PW'(1);
            end
            case ({acc, rel})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The accept cycle counts as age 0, so the entry is already age 1 once stored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (q_age[i] < LAT_C) begin
                q_age[i] <= q_age[i] + 4'd1;
            end
        end
        if (acc) begin
            q_wr[wptr]    <= data_sram_wr;
            q_rdata[wptr] <= data_sram_wr ? 32'd0 : mem[widx];
            q_age[wptr]   <= 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
